// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with an integrated transmit FIFO. Bytes pushed by a bus
//   master are serialised back-to-back, LSB first, with one start bit, an
//   optional parity bit and one or two stop bits. While the FIFO holds data
//   the next start bit immediately follows the last stop cycle.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> PARITY (0 none, 1 odd, 2 even) is honoured; the parity
//                  state and parity generator are built.
//     undefined -> no parity state or logic; PARITY has no effect.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   wr_en      in   write strobe, pushes wr_data when the FIFO is not full
//   wr_data    in   DATA_LEN-bit word to transmit
//   fifo_full  out  all FIFO_DEPTH entries occupied (registered)
//   fifo_empty out  FIFO holds no entries (registered)
//   tx_busy    out  a frame is on the line
//   tx_data    out  serial line, idle high
//   tx_done    out  one-cycle pulse at the end of every frame
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_LEN     = 8,
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [DATA_LEN-1:0] wr_data,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                tx_busy,
  output logic                tx_data,
  output logic                tx_done
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  // The clock counter must reach the longest period, which is the stop period.
  localparam int CLK_W     = $clog2(STOP_CLKS);
  localparam int BIT_W     = $clog2(DATA_LEN);

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON  = (PARITY != 0);
  localparam bit PAR_ODD = (PARITY == 1);
`else
  // Marks instances that request parity in a build where it is not compiled in.
  if (PARITY != 0) begin : g_parity_ignored
  end
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_LEN-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, empty_q;
  logic                push, pop;

  // A pop in the same cycle frees a slot, so a write into a full FIFO is
  // accepted when the FSM is popping.
  assign push    = wr_en && (!full_q || pop);
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are valid, so clearing them flushes the FIFO.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [CLK_W-1:0]    clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_LEN-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  assign bit_end = (clk_cnt_q == CLK_W'(CLKS_PER_BIT - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty_q) pop = 1'b1;
      end

      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == BIT_W'(DATA_LEN - 1)) begin
`ifdef UART_TX_PARITY_EN
            if (PAR_ON) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            // The line always carries bit 0 of the shift register.
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          tx_d      = 1'b1;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (clk_cnt_q == CLK_W'(STOP_CLKS - 1)) begin
          done_d    = 1'b1;
          clk_cnt_d = '0;
          if (!empty_q) begin
            pop = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Common frame launch from IDLE or from the last stop cycle: the word is
    // captured here so later FIFO writes cannot disturb the frame.
    if (pop) begin
      shift_d   = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      par_d     = (^mem_q[rd_ptr_q]) ^ PAR_ODD;
`endif
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      clk_cnt_d = '0;
      state_d   = S_START;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign tx_busy    = busy_q;
  assign tx_data    = tx_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Three instances share clock and reset:
//     u_dut0: PARITY=0, STOP_BITS=1 (reset, single frame, FIFO, reset mid-frame)
//     u_dut1: PARITY=2, STOP_BITS=2 (even parity, two stop bits)
//     u_dut2: PARITY=1, STOP_BITS=1 (odd parity)
//   All use DATA_LEN=8, CLKS_PER_BIT=4, FIFO_DEPTH=4. Stimulus pushes the
//   expected frame of every accepted byte into a per-instance queue; a monitor
//   per instance pops and compares the line cycle by cycle whenever a start
//   bit appears.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CPB = 4;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [11:0] bits;  // bit 0 = start bit, sent first
    logic [3:0]  len;
  } frame_t;

  logic       clk;
  logic       reset_n;
  logic [2:0] wr_en;
  logic [7:0] wr_data [3];
  logic [2:0] full_w, empty_w, busy_w, tx_w, done_w;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_fifo #(.DATA_LEN(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
    .fifo_full(full_w[0]), .fifo_empty(empty_w[0]), .tx_busy(busy_w[0]),
    .tx_data(tx_w[0]), .tx_done(done_w[0]));

  uart_tx_fifo #(.DATA_LEN(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
    .fifo_full(full_w[1]), .fifo_empty(empty_w[1]), .tx_busy(busy_w[1]),
    .tx_data(tx_w[1]), .tx_done(done_w[1]));

  uart_tx_fifo #(.DATA_LEN(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
    .fifo_full(full_w[2]), .fifo_empty(empty_w[2]), .tx_busy(busy_w[2]),
    .tx_data(tx_w[2]), .tx_done(done_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input int par_mode, input int stops);
    frame_t f;
    int     n;
    f.bits = '0;
    n      = 1;
    for (int k = 0; k < 8; k++) begin
      f.bits[n] = d[k];
      n++;
    end
    if (PAR_BUILD && par_mode != 0) begin
      f.bits[n] = (^d) ^ (par_mode == 1);
      n++;
    end
    for (int k = 0; k < stops; k++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = 4'(n);
    return f;
  endfunction

  // Per-instance monitor and expected-frame queue.
  for (genvar g = 0; g < 3; g++) begin : mon
    frame_t q[$];
    initial begin
      frame_t      f;
      logic [63:0] cap, expv;
      int          extra;
      bit          aborted;
      @(negedge clk);
      forever begin
        if (reset_n && tx_w[g] === 1'b0) begin
          if (q.size() == 0) begin
            check($sformatf("unexpected_frame_dut%0d", g), 1, 0);
            repeat (60) @(negedge clk);
          end else begin
            f       = q.pop_front();
            cap     = '0;
            expv    = '0;
            extra   = 0;
            aborted = 1'b0;
            for (int i = 0; i < int'(f.len) * CPB; i++) begin
              if (!reset_n) begin
                aborted = 1'b1;
                break;
              end
              cap[i]  = tx_w[g];
              expv[i] = f.bits[i / CPB];
              // Cycle 0 may carry the previous frame's done pulse.
              if (i > 0 && done_w[g]) extra++;
              @(negedge clk);
            end
            if (!aborted) begin
              check($sformatf("frame_line_dut%0d", g), cap, expv);
              check($sformatf("done_inside_frame_dut%0d", g), extra, 0);
              check($sformatf("done_pulse_dut%0d", g), done_w[g], 1);
            end
          end
        end else begin
          @(negedge clk);
        end
      end
    end
  end

  task automatic expect_byte(input int idx, input logic [7:0] d);
    case (idx)
      0:       mon[0].q.push_back(make_frame(d, 0, 1));
      1:       mon[1].q.push_back(make_frame(d, 2, 2));
      default: mon[2].q.push_back(make_frame(d, 1, 1));
    endcase
  endtask

  task automatic drive(input int idx, input logic [7:0] d);
    @(negedge clk);
    wr_en[idx]   = 1'b1;
    wr_data[idx] = d;
  endtask

  task automatic release_wr(input int idx);
    @(negedge clk);
    wr_en[idx] = 1'b0;
  endtask

  // Counts cycles with tx_busy high and tx_done pulses up to and including
  // the cycle after busy falls. Both loops are bounded.
  task automatic measure(input int idx, output int busy_cyc, output int dones);
    int guard;
    busy_cyc = 0;
    dones    = 0;
    guard    = 0;
    while (!busy_w[idx] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    while (busy_w[idx] && guard < 2000) begin
      busy_cyc++;
      if (done_w[idx]) dones++;
      @(negedge clk);
      guard++;
    end
    if (done_w[idx]) dones++;
  endtask

  logic [7:0] burst1 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] burst2 [5] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, dn, act;
    reset_n = 1'b0;
    wr_en   = '0;
    for (int i = 0; i < 3; i++) wr_data[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_tx_data",    tx_w[0],    1);
    check("reset_tx_busy",    busy_w[0],  0);
    check("reset_tx_done",    done_w[0],  0);
    check("reset_fifo_empty", empty_w[0], 1);
    check("reset_fifo_full",  full_w[0],  0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0xA5: empty falls after edge N, line falls after N+1
    drive(0, 8'hA5);
    expect_byte(0, 8'hA5);
    release_wr(0);
    check("wr_empty_falls", empty_w[0], 0);
    check("wr_not_busy_yet", busy_w[0], 0);
    check("wr_line_idle",    tx_w[0],   1);
    @(negedge clk);
    check("pop_line_low",    tx_w[0],     0);
    check("pop_busy_high",   busy_w[0],   1);
    check("pop_empty_again", empty_w[0],  1);
    measure(0, bc, dn);
    check("single_frame_cycles", bc, 40);
    check("single_frame_dones",  dn, 1);
    check("single_busy_low",     busy_w[0], 0);

    // Even parity, two stop bits
    drive(1, 8'hA5);
    expect_byte(1, 8'hA5);
    release_wr(1);
    measure(1, bc, dn);
    check("even_par_frame_cycles", bc, PAR_BUILD ? 48 : 44);
    check("even_par_dones",        dn, 1);

    // Odd parity over three ones
    drive(2, 8'h07);
    expect_byte(2, 8'h07);
    release_wr(2);
    measure(2, bc, dn);
    check("odd_par_frame_cycles", bc, PAR_BUILD ? 44 : 40);
    check("odd_par_dones",        dn, 1);

    // Six consecutive writes: the sixth hits a full FIFO and is dropped
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) check("burst_full_before_drop", full_w[0], 1);
      wr_en[0]   = 1'b1;
      wr_data[0] = burst1[i];
      if (i < 5) expect_byte(0, burst1[i]);
    end
    release_wr(0);
    check("burst_full_after_drop", full_w[0], 1);
    // First start after edge M+1, five 40-cycle frames end at M+201; counting
    // starts after edge M+5, so 196 busy cycles with no gap.
    measure(0, bc, dn);
    check("burst_busy_cycles", bc, 196);
    check("burst_dones",       dn, 5);
    check("burst_empty_end",   empty_w[0], 1);

    // Refill to full, then write on the cycle of the first back-to-back pop
    for (int i = 0; i < 5; i++) begin
      drive(0, burst2[i]);
      expect_byte(0, burst2[i]);
    end
    release_wr(0);
    repeat (36) @(negedge clk);
    check("pushpop_full_before", full_w[0], 1);
    check("pushpop_no_done_yet", done_w[0], 0);
    wr_en[0]   = 1'b1;
    wr_data[0] = 8'h77;
    expect_byte(0, 8'h77);
    @(negedge clk);
    wr_en[0] = 1'b0;
    check("pushpop_full_stays", full_w[0], 1);
    check("pushpop_on_pop",     done_w[0], 1);
    measure(0, bc, dn);
    check("pushpop_busy_cycles", bc, 200);
    check("pushpop_dones",       dn, 6);
    check("pushpop_empty_end",   empty_w[0], 1);

    // Reset during DATA with two entries queued behind the active frame
    drive(0, 8'h00);
    expect_byte(0, 8'h00);
    drive(0, 8'h3C);
    drive(0, 8'hC3);
    release_wr(0);
    repeat (6) @(negedge clk);
    check("pre_reset_line_low", tx_w[0],   0);
    check("pre_reset_busy",     busy_w[0], 1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midreset_tx_data",    tx_w[0],    1);
    check("midreset_tx_busy",    busy_w[0],  0);
    check("midreset_tx_done",    done_w[0],  0);
    check("midreset_fifo_empty", empty_w[0], 1);
    check("midreset_fifo_full",  full_w[0],  0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    act = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (busy_w[0] || !tx_w[0]) act++;
    end
    check("post_reset_no_frames", act, 0);
    check("post_reset_empty",     empty_w[0], 1);

    check("scoreboard_drained_dut0", mon[0].q.size(), 0);
    check("scoreboard_drained_dut1", mon[1].q.size(), 0);
    check("scoreboard_drained_dut2", mon[2].q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
